// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and state encoding for the uart_rx_ext receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Brief    : rx synchroniser, start-edge detect, bit timer and 3-sample voter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic run,
    output logic rx_s,
    output logic start_det,
    output logic bit_val,
    output logic bit_strobe,
    output logic bit_end
);

    localparam int            CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C_S0   = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] C_S1   = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] C_S2   = CW'(CLK_DIV / 2 + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q,  prev_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          smp0_q,  smp0_d;
    logic          smp1_q,  smp1_d;
    logic          val_q,   val_d;
    logic          stb_q,   stb_d;
    logic          w_major;

    // Third vote is the live synchronised sample at count H+1.
    assign w_major = (smp0_q & smp1_q) | (smp0_q & sync2_q) | (smp1_q & sync2_q);

    always_comb begin
        sync1_d = rx;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cnt_d   = '0;
        if (run && (cnt_q != C_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
        smp0_d = smp0_q;
        smp1_d = smp1_q;
        if (cnt_q == C_S0) smp0_d = sync2_q;
        if (cnt_q == C_S1) smp1_d = sync2_q;
        stb_d = run && (cnt_q == C_S2);
        val_d = stb_d ? w_major : val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            smp0_q  <= 1'b0;
            smp1_q  <= 1'b0;
            val_q   <= 1'b0;
            stb_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            smp0_q  <= smp0_d;
            smp1_q  <= smp1_d;
            val_q   <= val_d;
            stb_q   <= stb_d;
        end
    end

    assign rx_s       = sync2_q;
    assign start_det  = prev_q & ~sync2_q;
    assign bit_val    = val_q;
    assign bit_strobe = stb_q;
    assign bit_end    = run && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ext
// Brief    : Configurable UART receiver with error flags and valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int            IW          = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] C_LAST_DATA = IW'(DATA_BITS);
    localparam logic [IW-1:0] C_LAST_STOP = IW'(STOP_BITS - 1);
    localparam logic          C_ODD       = (PARITY == PAR_ODD);

    rx_state_e            state_q, state_d;
    logic [IW-1:0]        idx_q,   idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q,   par_d;
    logic                 frm_q,   frm_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q,  ferr_d;
    logic                 perr_q,  perr_d;
    logic                 ovr_q,   ovr_d;

    logic w_rx_s, w_start_det, w_bit_val, w_bit_strobe, w_bit_end;
    logic w_run, w_par_exp, w_done, w_frm_now;

    assign w_run = (state_q == S_START) || (state_q == S_DATA) ||
                   (state_q == S_PARITY) || (state_q == S_STOP);

    uart_rx_sampler #(
        .CLK_DIV (CLK_DIV)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .run        (w_run),
        .rx_s       (w_rx_s),
        .start_det  (w_start_det),
        .bit_val    (w_bit_val),
        .bit_strobe (w_bit_strobe),
        .bit_end    (w_bit_end)
    );

    assign w_par_exp = (^shreg_q) ^ C_ODD;
    // The word completes at the last stop decision, not at end of bit.
    assign w_done    = (state_q == S_STOP) && w_bit_strobe && (idx_q == C_LAST_STOP);
    assign w_frm_now = frm_q | ~w_bit_val;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        frm_d   = frm_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_det) begin
                    state_d = S_START;
                    par_d   = 1'b0;
                    frm_d   = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_strobe && w_bit_val) begin
                    state_d = S_IDLE;
                end else if (w_bit_end) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_strobe) begin
                    shreg_d = {w_bit_val, shreg_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                end
                if (w_bit_end && (idx_q == C_LAST_DATA)) begin
                    idx_d   = '0;
                    state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (w_bit_strobe && (w_bit_val != w_par_exp)) begin
                    par_d = 1'b1;
                end
                if (w_bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_strobe) begin
                    frm_d = w_frm_now;
                    if (idx_q == C_LAST_STOP) begin
                        state_d = w_frm_now ? S_BREAK : S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Holding register: a new word only lands if the slot is free or draining now.
    always_comb begin
        data_d  = data_q;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (w_done) begin
            if (!valid_q || rx_ready) begin
                data_d  = shreg_q;
                ferr_d  = w_frm_now;
                perr_d  = par_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            frm_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            frm_q   <= frm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ext
// Brief    : Self-checking bench for uart_rx_ext (even parity, 8 data, 1 stop).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ext;

    localparam int CLK_DIV   = 16;
    localparam int DATA_BITS = 8;
    localparam int PARITY    = 2;
    localparam int STOP_BITS = 1;
    localparam int H         = CLK_DIV / 2;
    localparam int NBITS     = 1 + DATA_BITS + 1 + STOP_BITS;

    logic                 clk      = 1'b0;
    logic                 rst_n    = 1'b0;
    logic                 rx       = 1'b1;
    logic                 rx_ready = 1'b1;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid, frame_err, parity_err, overrun, busy;

    uart_rx_ext #(
        .CLK_DIV   (CLK_DIV),
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic                 fe;
        logic                 pe;
    } exp_t;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic                 pbit;
        logic                 sbit;
        logic [DATA_BITS-1:0] exp_data;
        logic                 exp_fe;
        logic                 exp_pe;
    } vec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   rises    = 0;
    int   rise_cyc = 0;
    int   ovr_cnt  = 0;
    logic valid_prev = 1'b0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: the frame's parity bit plus the data ones must match the mode.
    function automatic logic good_pbit(input logic [DATA_BITS-1:0] d);
        int ones = 0;
        for (int i = 0; i < DATA_BITS; i++) ones += int'(d[i]);
        return (PARITY == 1) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    endfunction

    function automatic exp_t model(input logic [DATA_BITS-1:0] d, input logic pbit, input logic sbit);
        exp_t e;
        int   ones = 0;
        for (int i = 0; i < DATA_BITS; i++) ones += int'(d[i]);
        e.data = d;
        e.fe   = !sbit;
        e.pe   = (PARITY == 0) ? 1'b0 : logic'(((ones + int'(pbit)) % 2) != ((PARITY == 1) ? 1 : 0));
        return e;
    endfunction

    // Scoreboard: every accepted word must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rx_valid && !valid_prev) begin
            rises++;
            rise_cyc = cyc;
        end
        valid_prev = rx_valid;
        if (overrun) ovr_cnt++;
        if (rx_valid && rx_ready && rst_n) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got data 0x%0h, expected no word", rx_data);
            end else begin
                e = sb.pop_front();
                chk("rx_data", 32'(rx_data), 32'(e.data));
                chk("frame_err", 32'(frame_err), 32'(e.fe));
                chk("parity_err", 32'(parity_err), 32'(e.pe));
            end
        end
    end

    task automatic send_bit(input logic b, input logic glitch);
        for (int k = 0; k < CLK_DIV; k++) begin
            @(negedge clk);
            rx = (glitch && (k == H + 1)) ? ~b : b;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rx = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic pbit, input logic sbit,
                              input int glitch_bit, output int t0);
        t0 = 0;
        for (int k = 0; k < CLK_DIV; k++) begin
            @(negedge clk);
            if (k == 0) t0 = cyc;
            rx = 1'b0;
        end
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i], logic'(i == glitch_bit));
        if (PARITY != 0) send_bit(pbit, 1'b0);
        for (int i = 0; i < STOP_BITS; i++) send_bit(sbit, 1'b0);
        if (!sbit) idle(CLK_DIV);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   t, r0, o0, cnt;
        logic saw;
        logic [DATA_BITS-1:0] d;
        logic pb, sbt;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        #2;
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_parity_err", 32'(parity_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2 * CLK_DIV);

        // Directed vectors; the first also pins the completion latency.
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe});
            send_frame(vecs[i].data, vecs[i].pbit, vecs[i].sbit, -1, t);
            idle(2 * CLK_DIV);
            chk("vec_drained", 32'(sb.size()), 0);
            if (i == 0) chk("latency", 32'(rise_cyc - t), 32'(1 + (NBITS - 1) * CLK_DIV + H + 5));
        end

        // False start: 3-clock low pulse.
        r0 = rises;
        saw = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        for (int k = 0; k < 2 * CLK_DIV; k++) begin
            @(negedge clk);
            rx = 1'b1;
            #2;
            if (busy) begin
                saw = 1'b1;
                cnt++;
            end
        end
        chk("fs_busy_seen", 32'(saw), 1);
        chk("fs_busy_len_ok", 32'((cnt >= H + 2) && (cnt <= H + 4)), 1);
        chk("fs_busy_cleared", 32'(busy), 0);
        chk("fs_no_word", 32'(rises - r0), 0);

        // Break: 40 bit times low.
        r0 = rises;
        sb.push_back(model(8'h00, 1'b0, 1'b0));
        for (int k = 0; k < 40 * CLK_DIV; k++) begin
            @(negedge clk);
            rx = 1'b0;
        end
        #2;
        chk("brk_busy_held", 32'(busy), 1);
        chk("brk_one_word", 32'(rises - r0), 1);
        saw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rx = 1'b1;
            #2;
            if (!busy) saw = 1'b1;
        end
        chk("brk_busy_cleared", 32'(saw), 1);
        idle(CLK_DIV);
        sb.push_back(model(8'h5A, good_pbit(8'h5A), 1'b1));
        send_frame(8'h5A, good_pbit(8'h5A), 1'b1, -1, t);
        idle(2 * CLK_DIV);
        chk("brk_after_drained", 32'(sb.size()), 0);

        // Overrun: consumer stalled across two back-to-back words.
        @(negedge clk);
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        sb.push_back(model(8'h11, good_pbit(8'h11), 1'b1));
        send_frame(8'h11, good_pbit(8'h11), 1'b1, -1, t);
        send_frame(8'h22, good_pbit(8'h22), 1'b1, -1, t);
        idle(CLK_DIV);
        #2;
        chk("ovr_pulses", 32'(ovr_cnt - o0), 1);
        chk("ovr_hold_valid", 32'(rx_valid), 1);
        chk("ovr_hold_data", 32'(rx_data), 32'h11);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("ovr_accept_drop", 32'(rx_valid), 0);
        chk("ovr_drained", 32'(sb.size()), 0);

        // Glitch at count H of data bit 3, then reset in the middle of a frame.
        rx_ready = 1'b0;
        send_frame(8'h00, good_pbit(8'h00), 1'b1, 3, t);
        idle(CLK_DIV);
        #2;
        chk("glitch_valid", 32'(rx_valid), 1);
        chk("glitch_data", 32'(rx_data), 0);
        chk("glitch_parity_err", 32'(parity_err), 0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        #2;
        chk("mid_busy_before_rst", 32'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rx_valid), 0);
        chk("mid_rst_data", 32'(rx_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        idle(3);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        idle(2 * CLK_DIV);
        sb.push_back(model(8'h3C, good_pbit(8'h3C), 1'b1));
        send_frame(8'h3C, good_pbit(8'h3C), 1'b1, -1, t);
        idle(2 * CLK_DIV);
        chk("post_rst_drained", 32'(sb.size()), 0);

        // Randomised frames, including parity/stop errors and rejected glitches.
        o0 = ovr_cnt;
        for (int n = 0; n < 40; n++) begin
            d   = DATA_BITS'($urandom);
            pb  = good_pbit(d) ^ logic'($urandom_range(0, 3) == 0);
            sbt = logic'($urandom_range(0, 7) != 0);
            sb.push_back(model(d, pb, sbt));
            send_frame(d, pb, sbt, int'($urandom_range(0, 15)), t);
            idle(int'($urandom_range(0, 2)) * CLK_DIV);
        end
        idle(2 * CLK_DIV);
        chk("rand_drained", 32'(sb.size()), 0);
        chk("rand_no_overrun", 32'(ovr_cnt - o0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
